// File: rtl/sort_frame_loader.sv
// Collects 8 serial bytes into one parallel frame for an 8-input sorter.
// Optional macro SORT_LOADER_FLUSH_EN: flush emits a partial frame padded with PAD_VALUE.
module sort_frame_loader #(
    parameter int unsigned LATENCY   = 1,
    parameter logic [7:0]  PAD_VALUE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        in_hold,
    input  logic        flush,
    output logic [7:0]  out1,
    output logic [7:0]  out2,
    output logic [7:0]  out3,
    output logic [7:0]  out4,
    output logic [7:0]  out5,
    output logic [7:0]  out6,
    output logic [7:0]  out7,
    output logic [7:0]  out8,
    output logic        frame_valid,
    output logic        sort_valid,
    output logic [15:0] frame_cnt
);
    localparam int unsigned DW    = 8;
    localparam int unsigned NSLOT = 8;
    localparam int unsigned IW    = 3;
    localparam int unsigned CW    = 16;

    typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_t;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [DW-1:0]      fill_q [NSLOT];
    logic [DW-1:0]      out_q  [NSLOT];
    logic               frame_valid_q;
    logic               s_ready_q;
    logic [LATENCY-1:0] sv_pipe_q;
    logic [CW-1:0]      frame_cnt_q;

    logic               accept_c;
    logic               close_c;
    logic [DW-1:0]      frame_c [NSLOT];

    assign accept_c = s_valid && s_ready_q;

`ifdef SORT_LOADER_FLUSH_EN
    // Frame closes on the 8th byte, or on flush once at least one byte is held.
    assign close_c = (state_q == ST_FILL) &&
                     ((accept_c && (idx_q == IW'(NSLOT - 1))) ||
                      (flush && ((idx_q != '0) || accept_c)));

    always_comb begin
        for (int unsigned k = 0; k < NSLOT; k++) begin
            frame_c[k] = PAD_VALUE;
            if (IW'(k) < idx_q) begin
                frame_c[k] = fill_q[k];
            end else if ((IW'(k) == idx_q) && accept_c) begin
                frame_c[k] = s_data;
            end
        end
    end
`else
    logic flush_unused_c;

    assign close_c        = accept_c && (idx_q == IW'(NSLOT - 1));
    assign flush_unused_c = ^{flush, PAD_VALUE};

    always_comb begin
        for (int unsigned k = 0; k < NSLOT; k++) begin
            frame_c[k] = (k == NSLOT - 1) ? s_data : fill_q[k];
        end
    end
`endif

    // Collection FSM, frame transfer, valid pipeline and frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            idx_q         <= '0;
            s_ready_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            sv_pipe_q     <= '0;
            frame_cnt_q   <= '0;
            for (int unsigned k = 0; k < NSLOT; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            frame_valid_q <= 1'b0;
            sv_pipe_q     <= LATENCY'({sv_pipe_q, frame_valid_q});
            case (state_q)
                ST_FILL: begin
                    s_ready_q <= 1'b1;
                    if (close_c) begin
                        idx_q <= '0;
                        if (in_hold) begin
                            fill_q    <= frame_c;
                            state_q   <= ST_FULL;
                            s_ready_q <= 1'b0;
                        end else begin
                            out_q         <= frame_c;
                            frame_valid_q <= 1'b1;
                            frame_cnt_q   <= frame_cnt_q + CW'(1);
                        end
                    end else if (accept_c) begin
                        fill_q[idx_q] <= s_data;
                        idx_q         <= idx_q + IW'(1);
                    end
                end
                ST_FULL: begin
                    if (!in_hold) begin
                        out_q         <= fill_q;
                        frame_valid_q <= 1'b1;
                        frame_cnt_q   <= frame_cnt_q + CW'(1);
                        idx_q         <= '0;
                        state_q       <= ST_FILL;
                        s_ready_q     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign frame_valid = frame_valid_q;
    assign sort_valid  = sv_pipe_q[LATENCY-1];
    assign frame_cnt   = frame_cnt_q;
    assign out1        = out_q[0];
    assign out2        = out_q[1];
    assign out3        = out_q[2];
    assign out4        = out_q[3];
    assign out5        = out_q[4];
    assign out6        = out_q[5];
    assign out7        = out_q[6];
    assign out8        = out_q[7];
endmodule

// File: doc/sort_frame_loader.md
SORT_FRAME_LOADER -- requirements
Module: sort_frame_loader

Interface
REQ-001 Parameter LATENCY, default 1, meaning cycles from frame_valid to sort_valid (legal 1..4), matching the downstream sorter's register depth.
REQ-002 Parameter PAD_VALUE, default 8'hFF, meaning the byte used to fill unused slots of a flushed partial frame.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 s_data  input  8  serial sample byte.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_ready  output  1  loader can accept a byte.
REQ-008 in_hold  input  1  downstream requests frozen frame outputs.
REQ-009 flush  input  1  emit the current partial frame padded (see REQ-024).
REQ-010 out1..out8  output  8 each  parallel frame to the sorter's in1..in8; out1 = first byte received.
REQ-011 frame_valid  output  1  one-cycle pulse: new frame on out1..out8 this cycle.
REQ-012 sort_valid  output  1  frame_valid delayed by exactly LATENCY cycles.
REQ-013 frame_cnt  output  16  number of frames issued, modulo 2^16.

Function
REQ-014 A byte SHALL be accepted on any clock edge where s_valid=1 and s_ready=1, written to fill-buffer slot idx, and idx SHALL increment.
REQ-015 The block SHALL have two states: FILL (s_ready=1) and FULL (s_ready=0).
REQ-016 In FILL, accepting the 8th byte (idx=7) with in_hold=0 SHALL transfer at that edge: out1..out7 <= buffer slots 0..6, out8 <= s_data, idx <= 0, frame_valid=1 in the following cycle.
REQ-017 In FILL, accepting the 8th byte with in_hold=1 SHALL store it and enter FULL without changing out1..out8.
REQ-018 In FULL, the first edge with in_hold=0 SHALL transfer the buffer to out1..out8, pulse frame_valid in the following cycle, set idx=0 and return to FILL.
REQ-019 out1..out8 SHALL change only on a transfer edge and SHALL otherwise hold their values.
REQ-020 frame_valid SHALL be high for exactly one cycle per transfer; back-to-back frames SHALL produce pulses at least 8 cycles apart.
REQ-021 sort_valid SHALL come from a LATENCY-deep shift register of frame_valid.
REQ-022 frame_cnt SHALL increment by 1 on each transfer and wrap from 16'hFFFF to 0.
REQ-023 s_valid=1 while s_ready=0 SHALL have no effect; a source holding its byte SHALL see it accepted once s_ready returns.

Configuration
REQ-024 With macro SORT_LOADER_FLUSH_EN defined:
- flush=1 in FILL with idx>0 (after counting any byte accepted that same edge) SHALL fill the remaining slots with PAD_VALUE.
- It SHALL then transfer per REQ-016 when in_hold=0, or enter FULL per REQ-017 when in_hold=1.
- flush with idx=0 SHALL be ignored.
- flush in FULL SHALL be ignored.
- flush coinciding with the 8th byte SHALL produce a normal, unpadded frame.
REQ-025 Without SORT_LOADER_FLUSH_EN, the flush port SHALL exist but be ignored, and no padding logic SHALL be built.

Reset
REQ-026 While rst_n=0 at a clock edge:
- state <= FILL, idx <= 0.
- out1..out8 <= 0, frame_valid <= 0, sort_valid pipeline <= 0, frame_cnt <= 0.
- s_ready SHALL read 0 during the reset cycle.
REQ-027 Reset mid-frame or in FULL SHALL discard partially collected bytes, and no frame_valid SHALL result from them.

Verification
REQ-028 After reset, stream 8'h10..8'h17 with s_valid held high and in_hold=0 -> out1=8'h10 ... out8=8'h17, one frame_valid pulse, sort_valid exactly LATENCY cycles later, frame_cnt=1.
REQ-029 in_hold=1 while 8 bytes arrive -> s_ready=0 after the 8th byte, outputs unchanged; drop in_hold -> frame appears next cycle, s_ready=1.
REQ-030 Random s_valid gaps over 3 frames -> byte order preserved, 3 frame_valid pulses, frame_cnt=3.
REQ-031 With SORT_LOADER_FLUSH_EN: send 8'hA1, 8'hA2, 8'hA3, then flush -> out1..out3=A1..A3, out4..out8=8'hFF; without the macro, same stimulus -> no frame_valid.
REQ-032 Assert rst_n=0 after 5 bytes, then send 8 new bytes -> the frame contains only the 8 new bytes, frame_cnt=1.
REQ-033 Preload 65535 frames (forced counter) then issue one frame -> frame_cnt wraps to 0.
